// File: rtl/mesi_isc_pkg.sv
// Shared types and encodings for the coherence-bus broadcast initiator.
// Command/type encodings, the queued request record and the initiator FSM states.
package mesi_isc_pkg;

    localparam int PKG_ADDR_WIDTH     = 32;
    localparam int PKG_CMD_WIDTH      = 3;
    localparam int PKG_TYPE_WIDTH     = 2;
    localparam int PKG_ID_WIDTH       = 5;

    localparam logic [PKG_CMD_WIDTH-1:0] CBUS_CMD_NOP      = 3'd0;
    localparam logic [PKG_CMD_WIDTH-1:0] CBUS_CMD_WR_SNOOP = 3'd1;
    localparam logic [PKG_CMD_WIDTH-1:0] CBUS_CMD_RD_SNOOP = 3'd2;
    localparam logic [PKG_CMD_WIDTH-1:0] CBUS_CMD_EN_WR    = 3'd3;
    localparam logic [PKG_CMD_WIDTH-1:0] CBUS_CMD_EN_RD    = 3'd4;

    localparam logic [PKG_TYPE_WIDTH-1:0] BROAD_TYPE_NOP = 2'd0;
    localparam logic [PKG_TYPE_WIDTH-1:0] BROAD_TYPE_WR  = 2'd1;
    localparam logic [PKG_TYPE_WIDTH-1:0] BROAD_TYPE_RD  = 2'd2;

    typedef struct packed {
        logic [PKG_TYPE_WIDTH-1:0] broad_type;
        logic [1:0]                cpu_id;
        logic [PKG_ADDR_WIDTH-1:0] addr;
        logic [PKG_ID_WIDTH-1:0]   id;
    } broad_req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNOOP  = 2'd1,
        ST_ENABLE = 2'd2
    } state_t;

    function automatic logic is_legal_type(input logic [PKG_TYPE_WIDTH-1:0] t);
        return (t == BROAD_TYPE_WR) || (t == BROAD_TYPE_RD);
    endfunction

    function automatic logic [PKG_CMD_WIDTH-1:0] snoop_cmd(input logic [PKG_TYPE_WIDTH-1:0] t);
        return (t == BROAD_TYPE_WR) ? CBUS_CMD_WR_SNOOP : CBUS_CMD_RD_SNOOP;
    endfunction

    function automatic logic [PKG_CMD_WIDTH-1:0] enable_cmd(input logic [PKG_TYPE_WIDTH-1:0] t);
        return (t == BROAD_TYPE_WR) ? CBUS_CMD_EN_WR : CBUS_CMD_EN_RD;
    endfunction

endpackage

// File: rtl/mesi_broad_req_fifo.sv
// Small synchronous FIFO holding pending broadcast requests.
// not_full is a flop so the upstream ready never depends on same-cycle inputs.
module mesi_broad_req_fifo
    import mesi_isc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  broad_req_t push_data,
    input  logic       pop,
    output broad_req_t head,
    output logic       empty,
    output logic       not_full
);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_nx;
    logic             not_full_q;
    broad_req_t       mem [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_nx = count_q;
        if (push && !pop) begin
            count_nx = count_q + 1'b1;
        end else if (!push && pop) begin
            count_nx = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            not_full_q <= 1'b1;
        end else begin
            count_q    <= count_nx;
            not_full_q <= (count_nx != (PTR_W + 1)'(DEPTH));
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head     = mem[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign not_full = not_full_q;

endmodule

// File: rtl/mesi_cbus_broad_initiator.sv
// Coherence-bus broadcast initiator: queues requests, snoops the other three CPUs,
// then enables the originator and reports completion with the request ID.
module mesi_cbus_broad_initiator
    import mesi_isc_pkg::*;
#(
    parameter int ADDR_WIDTH               = 32,
    parameter int CBUS_CMD_WIDTH           = 3,
    parameter int BROAD_TYPE_WIDTH         = 2,
    parameter int BROAD_ID_WIDTH           = 5,
    parameter int BROAD_REQ_FIFO_SIZE      = 4,
    parameter int BROAD_REQ_FIFO_SIZE_LOG2 = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        broad_valid_i,
    output logic                        broad_ready_o,
    input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
    input  logic [1:0]                  broad_cpu_id_i,
    input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
    input  logic [BROAD_ID_WIDTH-1:0]   broad_id_i,
    output logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
    output logic [ADDR_WIDTH-1:0]       cbus_addr_o,
    input  logic [3:0]                  cbus_ack_array_i,
    output logic                        broad_done_o,
    output logic [BROAD_ID_WIDTH-1:0]   broad_done_id_o,
    output logic                        protocol_err_o
);

    // state  | meaning
    // IDLE   | waiting for a queued request; all ports NOP
    // SNOOP  | snoop commands out to the three non-originating CPUs
    // ENABLE | all snoops acked; originator holds EN_WR/EN_RD until it acks

    state_t                             state_q, state_nx;
    broad_req_t                         req_in, head;
    logic                               fifo_empty, fifo_not_full;
    logic                               push, illegal, pop, latch;
    logic [BROAD_TYPE_WIDTH-1:0]        cur_type_q;
    logic [1:0]                         cur_cpu_q;
    logic [BROAD_ID_WIDTH-1:0]          cur_id_q;
    logic [3:0][CBUS_CMD_WIDTH-1:0]     cmd_q, cmd_nx;
    logic [ADDR_WIDTH-1:0]              addr_q, addr_nx;
    logic                               done_q, done_nx;
    logic [BROAD_ID_WIDTH-1:0]          done_id_q, done_id_nx;
    logic                               err_q, err_nx;
    logic [3:0]                         active, acc, bad_ack;
    logic                               snoops_done;

    always_comb begin
        req_in.broad_type = broad_type_i;
        req_in.cpu_id     = broad_cpu_id_i;
        req_in.addr       = broad_addr_i;
        req_in.id         = broad_id_i;
    end

    assign push    = broad_valid_i && fifo_not_full && is_legal_type(broad_type_i);
    assign illegal = broad_valid_i && fifo_not_full && !is_legal_type(broad_type_i);

    mesi_broad_req_fifo #(
        .DEPTH (BROAD_REQ_FIFO_SIZE),
        .PTR_W (BROAD_REQ_FIFO_SIZE_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (req_in),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .not_full  (fifo_not_full)
    );

    // An ack only counts on a port currently driven with a real command.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            active[n] = (cmd_q[n] != CBUS_CMD_NOP);
        end
    end

    assign acc         = cbus_ack_array_i & active;
    assign bad_ack     = cbus_ack_array_i & ~active;
    assign snoops_done = ((active & ~acc) == 4'b0000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty)        state_nx = ST_SNOOP;
            ST_SNOOP:  if (snoops_done)        state_nx = ST_ENABLE;
            ST_ENABLE: if (acc[cur_cpu_q])     state_nx = ST_IDLE;
            default:                           state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_nx     = cmd_q;
        addr_nx    = addr_q;
        done_nx    = 1'b0;
        done_id_nx = done_id_q;
        err_nx     = err_q | illegal | (|bad_ack);
        pop        = 1'b0;
        latch      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    latch   = 1'b1;
                    addr_nx = head.addr;
                    for (int n = 0; n < 4; n++) begin
                        cmd_nx[n] = (n == int'(head.cpu_id)) ? CBUS_CMD_NOP
                                                             : snoop_cmd(head.broad_type);
                    end
                end
            end
            ST_SNOOP: begin
                for (int n = 0; n < 4; n++) begin
                    if (acc[n]) cmd_nx[n] = CBUS_CMD_NOP;
                end
                if (snoops_done) begin
                    cmd_nx[cur_cpu_q] = enable_cmd(cur_type_q);
                end
            end
            ST_ENABLE: begin
                if (acc[cur_cpu_q]) begin
                    cmd_nx[cur_cpu_q] = CBUS_CMD_NOP;
                    pop               = 1'b1;
                    done_nx           = 1'b1;
                    done_id_nx        = cur_id_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q      <= '0;
            addr_q     <= '0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            err_q      <= 1'b0;
            cur_type_q <= '0;
            cur_cpu_q  <= '0;
            cur_id_q   <= '0;
        end else begin
            cmd_q     <= cmd_nx;
            addr_q    <= addr_nx;
            done_q    <= done_nx;
            done_id_q <= done_id_nx;
            err_q     <= err_nx;
            if (latch) begin
                cur_type_q <= head.broad_type;
                cur_cpu_q  <= head.cpu_id;
                cur_id_q   <= head.id;
            end
        end
    end

    assign broad_ready_o    = fifo_not_full;
    assign cbus_cmd_array_o = cmd_q;
    assign cbus_addr_o      = addr_q;
    assign broad_done_o     = done_q;
    assign broad_done_id_o  = done_id_q;
    assign protocol_err_o   = err_q;

endmodule

// File: doc/mesi_cbus_broad_initiator.md
Name: mesi_cbus_broad_initiator

Overview:
- Drives the coherence bus (cbus) toward the four CPU ports; it is the initiator of the snoop protocol that each CPU answers with cbus_ack.
- Accepts broadcast requests (write or read miss from an originating CPU) into a small FIFO.
- For each request: issues a snoop command to the three other CPUs, then an enable command to the originator.
- Signals completion with a one-cycle done pulse carrying the request's broadcast ID.

Parameters:
- ADDR_WIDTH, 32, cbus/request address width
- CBUS_CMD_WIDTH, 3, per-CPU cbus command width
- BROAD_TYPE_WIDTH, 2, broadcast type width
- BROAD_ID_WIDTH, 5, broadcast transaction ID width
- BROAD_REQ_FIFO_SIZE, 4, request FIFO depth
- BROAD_REQ_FIFO_SIZE_LOG2, 2, FIFO pointer width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- broad_valid_i  in  1  broadcast request valid
- broad_ready_o  out  1  FIFO can accept (not full)
- broad_type_i  in  BROAD_TYPE_WIDTH  1=WR, 2=RD; 0 (NOP) and 3 are illegal
- broad_cpu_id_i  in  2  originating CPU
- broad_addr_i  in  ADDR_WIDTH  line address
- broad_id_i  in  BROAD_ID_WIDTH  transaction ID
- cbus_cmd_array_o  out  4*CBUS_CMD_WIDTH  per-CPU command; CPU n at bits [3n+2:3n]
- cbus_addr_o  out  ADDR_WIDTH  shared cbus address
- cbus_ack_array_i  in  4  per-CPU acknowledge
- broad_done_o  out  1  one-cycle completion pulse
- broad_done_id_o  out  BROAD_ID_WIDTH  ID of the completed request
- protocol_err_o  out  1  sticky error flag

Behaviour:
- cbus command encoding: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
- Reset (asynchronous assert, synchronous release):
  - FIFO empty; broad_ready_o=1.
  - All cbus_cmd fields NOP; cbus_addr_o=0.
  - broad_done_o=0; broad_done_id_o=0; protocol_err_o=0.
  - FSM=IDLE.
  - Reset mid-transaction discards the FIFO and the transaction in flight; no done pulse is issued.
- Push: broad_valid_i && broad_ready_o at a clock edge. broad_ready_o = !full, registered.
  - When full, a same-cycle pop does not enable a push.
  - An illegal type is not stored; it sets protocol_err_o.
- All outputs are registered.
- FSM states: IDLE, SNOOP, ENABLE.
- IDLE:
  - If the FIFO is non-empty at an edge, latch the head entry and go to SNOOP.
  - Next cycle: cbus_addr_o=head addr; every CPU != originator gets WR_SNOOP (type WR) or RD_SNOOP (type RD); originator gets NOP.
  - Minimum latency: push edge N → snoop commands visible after edge N+1.
- SNOOP:
  - Each pending CPU's command is held until cbus_ack_array_i[n]=1 is sampled with a non-NOP command on that port; that port then becomes NOP on the next cycle.
  - Acks from several CPUs in the same cycle are all accepted.
  - When the last pending ack is sampled, go to ENABLE. The next cycle, all snoop ports are NOP and the originator gets EN_WR/EN_RD.
- ENABLE:
  - On the originator's ack: originator cmd becomes NOP, FIFO pops, broad_done_o=1 for one cycle with the latched ID, FSM returns to IDLE.
  - If the FIFO is still non-empty, IDLE dispatches on the following edge. Back-to-back transactions therefore have one NOP cycle between them.
- cbus_addr_o is held stable for the whole transaction, from the SNOOP entry cycle through the ENABLE ack cycle.
- Ack on a port whose command is NOP: ignored, sets protocol_err_o. Cleared only by reset.
- Push while FIFO full is impossible by the handshake. Push and pop in the same cycle when not full: occupancy is unchanged.
- FIFO pointers wrap modulo BROAD_REQ_FIFO_SIZE. Occupancy is held in a BROAD_REQ_FIFO_SIZE_LOG2+1-bit counter.

Decomposition:
- Package mesi_isc_pkg:
  - cbus command localparams (NOP, WR_SNOOP, RD_SNOOP, EN_WR, EN_RD)
  - broadcast type localparams (NOP/WR/RD)
  - typedef struct broad_req_t {type, cpu_id, addr, id}
  - FSM state enum
- Sub-module mesi_broad_req_fifo: synchronous FIFO of broad_req_t, depth BROAD_REQ_FIFO_SIZE, providing full/empty/head.

Test Plan:
- WR from CPU 2, addr 0x0000_1040, id 5; CPUs 0, 1, 3 ack at staggered cycles (+1, +3, +2) → each port returns to NOP the cycle after its ack; then CPU 2 sees EN_WR (3); ack → broad_done_o pulses once with id 5; cbus_addr_o=0x0000_1040 throughout.
- RD from CPU 0, id 9; CPUs 1, 2, 3 all ack in the same cycle → single ENABLE transition; CPU 0 sees EN_RD (4); done with id 9.
- Push 5 requests with acks held low → broad_ready_o drops after the 4th push, the 5th is stalled; after the first done, ready reasserts; all 5 complete in push order with IDs preserved.
- Ack on CPU 1 while its command is NOP (IDLE) → protocol_err_o=1 and stays 1; the FSM is unaffected.
- Assert rst low in the SNOOP state with 3 entries queued → all commands NOP immediately (asynchronously); FIFO empty; no done pulse; broad_ready_o=1 after release.
- Push broad_type_i=0 → not stored; protocol_err_o=1; no cbus activity.
